dctq_zigzag_rle: RTL and testbench
==================================

// Module: dctq_zigzag_rle
// PURPOSE
//  Downstream neighbour of the DCTQ controller/datapath. Captures each 8x8 quantized block
//  (64 coefficients, raster order, qualified by dctq_valid with address addr) into a
//  ping-pong buffer. Reads it back in standard JPEG zigzag order and emits (run, level)
//  run-length symbols over a valid/ready handshake to the entropy coder.
// PARAMETERS
//  DATA_W  12  signed coefficient width (dctq_data, rle_level)
// PORTS
//  clk          in   1       system clock, all logic on posedge
//  reset_n      in   1       asynchronous active-low reset
//  dctq_valid   in   1       coefficient strobe from DCTQ (low during hold)
//  dctq_addr    in   6       raster index 0..63 of dctq_data (DCTQ addr)
//  dctq_data    in   DATA_W  signed quantized coefficient
//  rle_ready    in   1       downstream accepts symbol this cycle
//  rle_valid    out  1       symbol on rle_* valid
//  rle_run      out  6       zeros preceding rle_level in zigzag order
//  rle_level    out  DATA_W  nonzero coefficient value (0 for EOB)
//  rle_dc       out  1       symbol is the DC term (zigzag index 0)
//  rle_eob      out  1       end-of-block marker
//  blk_done     out  1       1-cycle pulse when EOB is accepted
//  overflow_err out  1       sticky: a block arrived while both banks were full
// BEHAVIOUR
//  Reset: all outputs 0; both banks empty; wr_bank=rd_bank=0; FSM=IDLE; run=0; k=0.
//  Write side:
//   - dctq_valid=1: store dctq_data at [wr_bank][dctq_addr]. Any address order is accepted.
//   - Write with dctq_addr=63: mark wr_bank full and toggle wr_bank.
//   - If the target bank is already full, the write is discarded and overflow_err is set.
//     overflow_err clears only on reset.
//  Read FSM, one zigzag index k per cycle unless stalled:
//   - IDLE -> SCAN: when rd_bank is full. k=0, run=0.
//   - SCAN, k=0: emit run=0, level=coef, rle_dc=1. The DC term is always emitted, even if 0.
//   - SCAN, k=1..63, coef=zz(k):
//     - coef=0: run<=run+1, no symbol.
//     - coef!=0: emit (run, coef), then run<=0.
//     - Maximum run is 62, so the 6-bit run never wraps.
//   - SCAN, k=63 processed: go to EOB.
//   - EOB: emit run=0, level=0, rle_eob=1. This is always sent, even if coef 63 is nonzero.
//   - On EOB acceptance: clear full[rd_bank], toggle rd_bank, pulse blk_done.
//     Next state is SCAN if the other bank is full, otherwise IDLE.
//  Handshake:
//   - rle_* are registered and change only when rle_valid=0 or rle_ready=1.
//   - While rle_valid=1 and rle_ready=0: hold k, run and outputs stable.
//   - rle_valid drops only after acceptance with no new symbol.
//  Latency:
//   - rle_valid rises 1 cycle after the clock edge that writes addr 63 into an empty
//     read bank with FSM in IDLE.
//   - With rle_ready=1 throughout, a block takes 64 scan cycles + 1 EOB cycle, back-to-back.
//  Simultaneous events:
//   - The release of full[b] on EOB acceptance and the completion of a write to bank b
//     in the same cycle count as a legal write: no overflow; bank b is full again.
//   - Write and read of different banks in the same cycle are independent.
//  Zigzag LUT: standard JPEG order 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,... ,55,62,63.
//  Reset mid-operation discards both banks and any pending symbol; no blk_done is generated.
// TESTING
//  T1: block all zero except raster0=5
//      -> (run0, 5, dc), then EOB; blk_done once; 2 symbols total.
//  T2: raster0=0, raster1=3, raster8=-2, rest 0
//      -> (0,0,dc), (0,3), (0,-2), EOB.
//  T3: raster63=7, rest 0
//      -> (0,0,dc), (62,7), EOB; run is not truncated.
//  T4: T2 block with rle_ready low for 10 cycles on the 2nd symbol
//      -> rle_* held stable, no symbol lost or duplicated.
//  T5: 3 blocks back-to-back, rle_ready=0 -> overflow_err=1 after the 3rd block; raise rle_ready
//      -> blocks 1 and 2 emitted intact, 2 blk_done pulses.
//  T6: reset_n low mid-SCAN of block 1, then new block of T1
//      -> outputs 0 during reset; only T1 symbols emitted after.

Source files
------------

// File: rtl/dctq_zigzag_rle.sv
// Ping-pong capture of 8x8 quantized blocks, zigzag readout as registered (run, level) symbols.
// First symbol 1 cycle after addr 63 lands; rle_* stall (k/run frozen) while rle_valid & !rle_ready.
module dctq_zigzag_rle #(
  parameter int DATA_W = 12
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     dctq_valid,
  input  logic [5:0]               dctq_addr,
  input  logic signed [DATA_W-1:0] dctq_data,
  input  logic                     rle_ready,
  output logic                     rle_valid,
  output logic [5:0]               rle_run,
  output logic signed [DATA_W-1:0] rle_level,
  output logic                     rle_dc,
  output logic                     rle_eob,
  output logic                     blk_done,
  output logic                     overflow_err
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EOB, S_EOB_WAIT} state_t;

  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic signed [DATA_W-1:0] mem_q [2][64];

  state_t                   state_q, state_d;
  logic [1:0]               full_q, full_d;
  logic                     wr_bank_q, wr_bank_d;
  logic                     rd_bank_q, rd_bank_d;
  logic [5:0]               k_q, k_d;
  logic [5:0]               zrun_q, zrun_d;
  logic                     vld_q, vld_d;
  logic [5:0]               run_q, run_d;
  logic signed [DATA_W-1:0] level_q, level_d;
  logic                     dc_q, dc_d;
  logic                     eob_q, eob_d;
  logic                     ovf_q, ovf_d;

  logic                     rd_other;
  logic                     can_adv;
  logic                     release_w;
  logic                     wr_ok;
  logic signed [DATA_W-1:0] coef;

  assign rd_other = ~rd_bank_q;
  assign can_adv  = ~vld_q | rle_ready;
  assign coef     = mem_q[rd_bank_q][ZZ[k_q]];

  // A bank freed by EOB acceptance this cycle may take a write in the same cycle.
  assign wr_ok = dctq_valid &
                 (~full_q[wr_bank_q] | (release_w & (rd_bank_q == wr_bank_q)));

  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    ovf_d     = ovf_q | (dctq_valid & ~wr_ok);
    if (release_w) full_d[rd_bank_q] = 1'b0;
    if (wr_ok && dctq_addr == 6'd63) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    k_d       = k_q;
    zrun_d    = zrun_q;
    vld_d     = vld_q;
    run_d     = run_q;
    level_d   = level_q;
    dc_d      = dc_q;
    eob_d     = eob_q;
    release_w = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (full_q[rd_bank_q]) begin
          vld_d   = 1'b1;
          run_d   = 6'd0;
          level_d = mem_q[rd_bank_q][0];
          dc_d    = 1'b1;
          eob_d   = 1'b0;
          k_d     = 6'd1;
          zrun_d  = 6'd0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (can_adv) begin
          dc_d  = 1'b0;
          eob_d = 1'b0;
          if (coef != '0) begin
            vld_d   = 1'b1;
            run_d   = zrun_q;
            level_d = coef;
            zrun_d  = 6'd0;
          end else begin
            vld_d  = 1'b0;
            zrun_d = zrun_q + 6'd1;
          end
          k_d = k_q + 6'd1;
          if (k_q == 6'd63) state_d = S_EOB;
        end
      end
      S_EOB: begin
        if (can_adv) begin
          vld_d   = 1'b1;
          run_d   = 6'd0;
          level_d = '0;
          dc_d    = 1'b0;
          eob_d   = 1'b1;
          state_d = S_EOB_WAIT;
        end
      end
      default: begin
        if (rle_ready) begin
          release_w = 1'b1;
          rd_bank_d = rd_other;
          // Other bank already waiting: emit its DC on this edge to stay back-to-back.
          if (full_q[rd_other]) begin
            vld_d   = 1'b1;
            run_d   = 6'd0;
            level_d = mem_q[rd_other][0];
            dc_d    = 1'b1;
            eob_d   = 1'b0;
            k_d     = 6'd1;
            zrun_d  = 6'd0;
            state_d = S_SCAN;
          end else begin
            vld_d   = 1'b0;
            eob_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_bank_q][dctq_addr] <= dctq_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      k_q       <= 6'd0;
      zrun_q    <= 6'd0;
      vld_q     <= 1'b0;
      run_q     <= 6'd0;
      level_q   <= '0;
      dc_q      <= 1'b0;
      eob_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      k_q       <= k_d;
      zrun_q    <= zrun_d;
      vld_q     <= vld_d;
      run_q     <= run_d;
      level_q   <= level_d;
      dc_q      <= dc_d;
      eob_q     <= eob_d;
      ovf_q     <= ovf_d;
    end
  end

  assign rle_valid    = vld_q;
  assign rle_run      = run_q;
  assign rle_level    = level_q;
  assign rle_dc       = dc_q;
  assign rle_eob      = eob_q;
  assign blk_done     = release_w;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_dctq_zigzag_rle.sv
// Directed bench for dctq_zigzag_rle: hand-built blocks, expected symbol lists per scenario.
module tb_dctq_zigzag_rle;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              dctq_valid;
  logic [5:0]        dctq_addr;
  logic signed [11:0] dctq_data;
  logic              rle_ready;
  logic              rle_valid;
  logic [5:0]        rle_run;
  logic signed [11:0] rle_level;
  logic              rle_dc;
  logic              rle_eob;
  logic              blk_done;
  logic              overflow_err;

  dctq_zigzag_rle #(.DATA_W(12)) dut (
    .clk(clk), .reset_n(reset_n),
    .dctq_valid(dctq_valid), .dctq_addr(dctq_addr), .dctq_data(dctq_data),
    .rle_ready(rle_ready), .rle_valid(rle_valid), .rle_run(rle_run),
    .rle_level(rle_level), .rle_dc(rle_dc), .rle_eob(rle_eob),
    .blk_done(blk_done), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  run;
    logic [11:0] level;
    logic        dc;
    logic        eob;
  } sym_t;

  int   vectors = 0;
  int   miscompares = 0;
  int   done_cnt = 0;
  sym_t got[$];
  sym_t exp_q[$];
  logic signed [11:0] blk [64];

  always @(negedge clk) begin
    if (reset_n && rle_valid && rle_ready)
      got.push_back({rle_run, rle_level, rle_dc, rle_eob});
    if (blk_done) done_cnt++;
  end

  function automatic sym_t mk(input int run, input int lv, input bit dc, input bit eob);
    logic [11:0] l;
    l = lv[11:0];
    return {run[5:0], l, dc, eob};
  endfunction

  task automatic pat_t1();
    foreach (blk[i]) blk[i] = '0;
    blk[0] = 12'sd5;
  endtask

  task automatic pat_t2();
    foreach (blk[i]) blk[i] = '0;
    blk[1] = 12'sd3;
    blk[8] = -12'sd2;
  endtask

  task automatic pat_t3();
    foreach (blk[i]) blk[i] = '0;
    blk[63] = 12'sd7;
  endtask

  task automatic push_t1();
    exp_q.push_back(mk(0, 5, 1, 0)); exp_q.push_back(mk(0, 0, 0, 1));
  endtask

  task automatic push_t2();
    exp_q.push_back(mk(0, 0, 1, 0)); exp_q.push_back(mk(0, 3, 0, 0));
    exp_q.push_back(mk(0, -2, 0, 0)); exp_q.push_back(mk(0, 0, 0, 1));
  endtask

  task automatic push_t3();
    exp_q.push_back(mk(0, 0, 1, 0)); exp_q.push_back(mk(62, 7, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 1));
  endtask

  // Called at posedge+1; the addr-63 write lands on the last edge of the loop.
  task automatic send_block();
    for (int i = 0; i < 64; i++) begin
      dctq_valid = 1'b1;
      dctq_addr  = i[5:0];
      dctq_data  = blk[i];
      @(posedge clk); #1;
    end
    dctq_valid = 1'b0;
  endtask

  task automatic wait_done(input int n, output bit ok);
    int c;
    c = 0;
    while (done_cnt < n && c < 2000) begin
      @(negedge clk);
      c++;
    end
    ok = (done_cnt >= n);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; dctq_valid = 1'b0; dctq_addr = '0; dctq_data = '0; rle_ready = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (rle_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid: got %b exp 0", rle_valid);
    end
    vectors++;
    if ({rle_run, rle_level, rle_dc, rle_eob, blk_done, overflow_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h exp 0",
               {rle_run, rle_level, rle_dc, rle_eob, blk_done, overflow_err});
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_dc_only();
    bit ok;
    int cyc;
    got.delete(); exp_q.delete(); done_cnt = 0; rle_ready = 1'b1;
    pat_t1(); push_t1();
    send_block();
    vectors++;
    if (rle_valid !== 1'b0) begin
      miscompares++; $display("FAIL t1_early_valid: got %b exp 0", rle_valid);
    end
    @(posedge clk); #1;
    vectors++;
    if ({rle_valid, rle_dc, rle_level} !== {1'b1, 1'b1, 12'sd5}) begin
      miscompares++;
      $display("FAIL t1_latency: got v=%b dc=%b lv=%0d exp v=1 dc=1 lv=5", rle_valid, rle_dc, rle_level);
    end
    cyc = 0;
    while (cyc < 200) begin
      @(negedge clk);
      if (blk_done) break;
      cyc++;
    end
    vectors++;
    if (cyc !== 64) begin
      miscompares++; $display("FAIL t1_block_cycles: got %0d exp 64", cyc);
    end
    wait_done(1, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL t1_timeout: got %0d blk_done exp 1", done_cnt); end
    vectors++;
    if (got.size() !== exp_q.size() || done_cnt !== 1) begin
      miscompares++;
      $display("FAIL t1_count: got %0d syms %0d done exp %0d syms 1 done", got.size(), done_cnt, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        vectors++;
        if (got[i] !== exp_q[i]) begin
          miscompares++; $display("FAIL t1_sym%0d: got %h exp %h", i, got[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_pattern(input int which);
    bit ok;
    got.delete(); exp_q.delete(); done_cnt = 0; rle_ready = 1'b1;
    if (which == 2) begin pat_t2(); push_t2(); end
    else begin pat_t3(); push_t3(); end
    send_block();
    wait_done(1, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL t%0d_timeout: got %0d blk_done exp 1", which, done_cnt); end
    vectors++;
    if (got.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL t%0d_count: got %0d exp %0d", which, got.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        vectors++;
        if (got[i] !== exp_q[i]) begin
          miscompares++; $display("FAIL t%0d_sym%0d: got %h exp %h", which, i, got[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    int c;
    logic [20:0] snap;
    got.delete(); exp_q.delete(); done_cnt = 0; rle_ready = 1'b1;
    pat_t2(); push_t2();
    send_block();
    c = 0;
    while (!(rle_valid && !rle_dc && rle_level == 12'sd3) && c < 100) begin
      @(posedge clk); #1; c++;
    end
    rle_ready = 1'b0;
    vectors++;
    if (c >= 100) begin miscompares++; $display("FAIL t4_find_sym: got timeout exp level 3"); end
    snap = {rle_valid, rle_run, rle_level, rle_dc, rle_eob};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if ({rle_valid, rle_run, rle_level, rle_dc, rle_eob} !== snap) begin
        miscompares++;
        $display("FAIL t4_hold%0d: got %h exp %h", i, {rle_valid, rle_run, rle_level, rle_dc, rle_eob}, snap);
      end
    end
    @(posedge clk); #1;
    rle_ready = 1'b1;
    wait_done(1, ok);
    vectors++;
    if (!ok || got.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL t4_count: got %0d syms exp %0d", got.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        vectors++;
        if (got[i] !== exp_q[i]) begin
          miscompares++; $display("FAIL t4_sym%0d: got %h exp %h", i, got[i], exp_q[i]);
        end
      end
    end
  endtask

  // addr-63 write into the bank whose EOB is accepted on the same edge.
  task automatic test_release_write();
    bit ok;
    int c;
    got.delete(); exp_q.delete(); done_cnt = 0; rle_ready = 1'b0;
    pat_t1(); send_block();
    pat_t3(); send_block();
    c = 0;
    while (!(rle_valid && rle_eob) && c < 500) begin
      rle_ready = 1'b1;
      @(posedge clk); #1; c++;
    end
    rle_ready  = 1'b0;
    dctq_valid = 1'b1; dctq_addr = 6'd63; dctq_data = 12'sd9; rle_ready = 1'b1;
    @(posedge clk); #1;
    dctq_valid = 1'b0;
    vectors++;
    if (c >= 500) begin miscompares++; $display("FAIL rw_find_eob: got timeout exp EOB"); end
    @(negedge clk);
    vectors++;
    if (overflow_err !== 1'b0) begin
      miscompares++; $display("FAIL rw_overflow: got %b exp 0", overflow_err);
    end
    push_t1(); push_t3();
    exp_q.push_back(mk(0, 5, 1, 0)); exp_q.push_back(mk(62, 9, 0, 0)); exp_q.push_back(mk(0, 0, 0, 1));
    wait_done(3, ok);
    vectors++;
    if (!ok || got.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL rw_count: got %0d syms %0d done exp %0d syms 3 done", got.size(), done_cnt, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        vectors++;
        if (got[i] !== exp_q[i]) begin
          miscompares++; $display("FAIL rw_sym%0d: got %h exp %h", i, got[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    got.delete(); exp_q.delete(); done_cnt = 0; rle_ready = 1'b0;
    pat_t1(); send_block();
    pat_t3(); send_block();
    vectors++;
    if (overflow_err !== 1'b0) begin
      miscompares++; $display("FAIL t5_ovf_early: got %b exp 0", overflow_err);
    end
    pat_t2(); send_block();
    vectors++;
    if (overflow_err !== 1'b1) begin
      miscompares++; $display("FAIL t5_ovf_set: got %b exp 1", overflow_err);
    end
    rle_ready = 1'b1;
    push_t1(); push_t3();
    wait_done(2, ok);
    repeat (200) @(posedge clk);
    #1;
    vectors++;
    if (!ok || done_cnt !== 2 || got.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL t5_count: got %0d syms %0d done exp %0d syms 2 done", got.size(), done_cnt, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        vectors++;
        if (got[i] !== exp_q[i]) begin
          miscompares++; $display("FAIL t5_sym%0d: got %h exp %h", i, got[i], exp_q[i]);
        end
      end
    end
    vectors++;
    if (overflow_err !== 1'b1) begin
      miscompares++; $display("FAIL t5_ovf_sticky: got %b exp 1", overflow_err);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    rle_ready = 1'b1;
    pat_t3(); send_block();
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({rle_valid, rle_run, rle_level, rle_dc, rle_eob, blk_done, overflow_err} !== '0) begin
      miscompares++;
      $display("FAIL t6_reset_outputs: got %h exp 0",
               {rle_valid, rle_run, rle_level, rle_dc, rle_eob, blk_done, overflow_err});
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    got.delete(); exp_q.delete(); done_cnt = 0;
    @(posedge clk); #1;
    pat_t1(); push_t1();
    send_block();
    wait_done(1, ok);
    repeat (100) @(posedge clk);
    #1;
    vectors++;
    if (!ok || done_cnt !== 1 || got.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL t6_count: got %0d syms %0d done exp %0d syms 1 done", got.size(), done_cnt, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        vectors++;
        if (got[i] !== exp_q[i]) begin
          miscompares++; $display("FAIL t6_sym%0d: got %h exp %h", i, got[i], exp_q[i]);
        end
      end
    end
    vectors++;
    if (overflow_err !== 1'b0) begin
      miscompares++; $display("FAIL t6_ovf_cleared: got %b exp 0", overflow_err);
    end
  endtask

  initial begin
    test_reset();
    test_dc_only();
    test_pattern(2);
    test_pattern(3);
    test_stall();
    test_release_write();
    test_overflow();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
